// File: rtl/mips32_mem_responder.sv
// Word-addressed memory target for the MIPS32 core: req/ack handshake with programmable
// wait states, out-of-range error reporting and a backdoor preload port usable while idle.
module mips32_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              busy,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem [DEPTH];

    // Range check on the full captured address so aliasing upper bits are rejected.
    logic in_range;
    assign in_range = (addr_q < 32'(DEPTH));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = dbg_addr;
        mem_wdata = dbg_wdata;

        case (state_q)
            IDLE: begin
                if (dbg_we) begin
                    mem_we = 1'b1;
                end else if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (in_range) begin
                        if (we_q) begin
                            mem_we    = 1'b1;
                            mem_waddr = addr_q[ADDR_W-1:0];
                            mem_wdata = wdata_q;
                            rdata_d   = 32'd0;
                        end else begin
                            rdata_d = mem[addr_q[ADDR_W-1:0]];
                        end
                        err_d = 1'b0;
                    end else begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is never cleared; writes are blocked while reset is held so an aborted store cannot land.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign ack   = (state_q == RESP);
    assign busy  = (state_q != IDLE);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule
